// File: rtl/ac_alu_seq_if.sv
// ac_alu_seq_if: control-side bundle between the downsample sequencer and its neighbours.
interface ac_alu_seq_if;
  logic       start;
  logic       avg_mode;
  logic       opnd_req;
  logic       opnd_valid;
  logic       bus_sel_ac;
  logic [1:0] ac_control;
  logic [2:0] alu_control;
  logic [6:0] inst_const;
  logic       z_flag;
  logic       busy;
  logic       done;
  logic       result_zero;
  modport master (
    output start, avg_mode, opnd_valid, z_flag,
    input  opnd_req, bus_sel_ac, ac_control, alu_control, inst_const, busy, done, result_zero
  );
  modport slave (
    input  start, avg_mode, opnd_valid, z_flag,
    output opnd_req, bus_sel_ac, ac_control, alu_control, inst_const, busy, done, result_zero
  );
endinterface

// File: rtl/ac_alu_seq.sv
// ac_alu_seq: sequences AC/ALU to load, accumulate 2^LOG2_N operands and optionally average them.
module ac_alu_seq #(
  parameter int LOG2_N = 2
) (
  input logic        clk,
  input logic        rst,
  ac_alu_seq_if.slave io
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACCUM, S_SHIFT, S_DONE} state_t;
  localparam logic [4:0] LAST = 5'((1 << LOG2_N) - 1);
  state_t     r_state, w_state;
  logic [4:0] r_cnt, w_cnt;
  logic       r_mode, w_mode;
  logic       w_in, w_acc;
  assign w_in  = (r_state == S_LOAD) || (r_state == S_ACCUM);
  assign w_acc = w_in & io.opnd_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_mode  <= w_mode;
    end
  end
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_mode  = r_mode;
    case (r_state)
      S_IDLE: if (io.start) begin
        w_mode  = io.avg_mode;
        w_cnt   = '0;
        w_state = S_LOAD;
      end
      S_LOAD: if (w_acc) begin
        w_cnt   = 5'd1;
        w_state = (LOG2_N == 0) ? (r_mode ? S_SHIFT : S_DONE) : S_ACCUM;
      end
      S_ACCUM: if (w_acc) begin
        w_cnt = r_cnt + 5'd1;
        if (r_cnt == LAST) w_state = r_mode ? S_SHIFT : S_DONE;
      end
      S_SHIFT: w_state = S_DONE;
      default: w_state = S_IDLE;
    endcase
  end
  // ADD sums AC + bus + const, so the constant stays zero outside SHIFT
  assign io.opnd_req    = w_in;
  assign io.ac_control  = (r_state == S_LOAD)  ? {io.opnd_valid, 1'b0} :
                          (r_state == S_ACCUM) ? {io.opnd_valid, 1'b1} :
                          (r_state == S_SHIFT) ? 2'b11 : 2'b00;
  assign io.bus_sel_ac  = r_state == S_SHIFT;
  assign io.alu_control = (r_state == S_SHIFT) ? 3'b100 : 3'b000;
  assign io.inst_const  = (r_state == S_SHIFT) ? 7'(LOG2_N) : 7'd0;
  assign io.busy        = r_state != S_IDLE;
  assign io.done        = r_state == S_DONE;
  assign io.result_zero = io.done & io.z_flag;
endmodule

// File: tb/tb_ac_alu_seq.sv
// tb_ac_alu_seq: directed checks of the sequencer driving a behavioural AC/ALU model.
module tb_ac_alu_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  ac_alu_seq_if u_if ();
  ac_alu_seq_if u_if1 ();
  logic        start, avg, valid;
  logic [15:0] opnd;
  logic [15:0] ops [4];
  int          dsel;
  int          dn;
  int          n_chk = 0;
  int          n_pass = 0;
  assign u_if.start       = start & (dsel == 0);
  assign u_if1.start      = start & (dsel == 1);
  assign u_if.avg_mode    = avg;
  assign u_if1.avg_mode   = avg;
  assign u_if.opnd_valid  = valid;
  assign u_if1.opnd_valid = valid;
  ac_alu_seq #(.LOG2_N(2)) u_dut  (.clk(clk), .rst(rst), .io(u_if));
  ac_alu_seq #(.LOG2_N(0)) u_dut1 (.clk(clk), .rst(rst), .io(u_if1));
  logic [15:0] ac0, ac1, bus0, bus1, alu0, alu1;
  assign bus0 = u_if.bus_sel_ac ? ac0 : opnd;
  assign bus1 = u_if1.bus_sel_ac ? ac1 : opnd;
  assign alu0 = (u_if.alu_control == 3'b100) ? bus0 >> u_if.inst_const : ac0 + bus0 + {9'd0, u_if.inst_const};
  assign alu1 = (u_if1.alu_control == 3'b100) ? bus1 >> u_if1.inst_const : ac1 + bus1 + {9'd0, u_if1.inst_const};
  assign u_if.z_flag  = ac0 == 16'd0;
  assign u_if1.z_flag = ac1 == 16'd0;
  always @(posedge clk) begin
    if (u_if.ac_control[1]) ac0 <= u_if.ac_control[0] ? alu0 : bus0;
    if (u_if1.ac_control[1]) ac1 <= u_if1.ac_control[0] ? alu1 : bus1;
  end
  logic        m_req, m_sel, m_done, m_busy, m_rz;
  logic [1:0]  m_acw;
  logic [6:0]  m_const;
  logic [15:0] m_ac;
  assign m_req   = (dsel == 1) ? u_if1.opnd_req    : u_if.opnd_req;
  assign m_sel   = (dsel == 1) ? u_if1.bus_sel_ac  : u_if.bus_sel_ac;
  assign m_done  = (dsel == 1) ? u_if1.done        : u_if.done;
  assign m_busy  = (dsel == 1) ? u_if1.busy        : u_if.busy;
  assign m_rz    = (dsel == 1) ? u_if1.result_zero : u_if.result_zero;
  assign m_acw   = (dsel == 1) ? u_if1.ac_control  : u_if.ac_control;
  assign m_const = (dsel == 1) ? u_if1.inst_const  : u_if.inst_const;
  assign m_ac    = (dsel == 1) ? ac1 : ac0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask
  task automatic run_job(input string tag, input logic a, input int n, input int gap, input bit poke,
                         input int exp_cyc, input logic [15:0] exp_ac, input logic exp_z, input logic [6:0] exp_k);
    int cyc = 0;
    int i = 0;
    int g = 0;
    int extra = 0;
    bit sel = 0;
    bit poked = 0;
    logic [6:0] k = '0;
    @(negedge clk);
    start = 1'b1;
    avg = a;
    valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({tag, "_busy"}, 32'(m_busy), 32'd1);
    while (!m_done && cyc < 64) begin
      start = 1'b0;
      if (poke && !poked && i == 2) begin
        start = 1'b1;
        poked = 1;
      end
      valid = m_req && i < n && !(i > 0 && g < gap);
      if (valid) opnd = ops[i];
      else if (m_req) g++;
      #1;
      if (m_req && !valid) chk({tag, "_gap_nowrite"}, 32'(m_acw[1]), 32'd0);
      if (m_sel) begin
        sel = 1;
        k = m_const;
      end
      if (m_req && valid) begin
        i++;
        g = 0;
      end
      @(negedge clk);
      cyc++;
    end
    valid = 1'b0;
    start = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_done"}, 32'(m_done), 32'd1);
    chk({tag, "_ac"}, 32'(m_ac), 32'(exp_ac));
    chk({tag, "_rzero"}, 32'(m_rz), 32'(exp_z));
    chk({tag, "_shift_seen"}, 32'(sel), 32'(a));
    if (sel) chk({tag, "_shift_const"}, 32'(k), 32'(exp_k));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(m_done), 32'd0);
    chk({tag, "_busy_off"}, 32'(m_busy), 32'd0);
    repeat (4) begin
      @(negedge clk);
      extra += int'(m_done);
    end
    chk({tag, "_no_extra_done"}, 32'(extra), 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    avg = 1'b0;
    valid = 1'b0;
    opnd = '0;
    dsel = 0;
    repeat (2) @(negedge clk);
    valid = 1'b1;
    #1;
    chk("reset_busy", 32'(u_if.busy), 32'd0);
    chk("reset_req", 32'(u_if.opnd_req), 32'd0);
    chk("reset_acctl", 32'(u_if.ac_control), 32'd0);
    chk("reset_done", 32'(u_if.done), 32'd0);
    chk("reset_busy_n1", 32'(u_if1.busy), 32'd0);
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b0;
    ops = '{16'd10, 16'd20, 16'd30, 16'd40};
    run_job("avg", 1'b1, 4, 0, 0, 6, 16'd25, 1'b0, 7'd2);
    run_job("sum", 1'b0, 4, 0, 0, 5, 16'd100, 1'b0, 7'd0);
    ops = '{16'd3, 16'd3, 16'd3, 16'd4};
    run_job("stall", 1'b1, 4, 2, 0, 12, 16'd3, 1'b0, 7'd2);
    ops = '{16'd0, 16'd0, 16'd0, 16'd0};
    run_job("zero", 1'b1, 4, 0, 1, 6, 16'd0, 1'b1, 7'd2);
    @(negedge clk);
    start = 1'b1;
    avg = 1'b1;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b1;
    opnd = 16'd5;
    @(negedge clk);
    opnd = 16'd6;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(u_if.opnd_req), 32'd0);
    chk("midrst_acctl", 32'(u_if.ac_control), 32'd0);
    chk("midrst_busy", 32'(u_if.busy), 32'd0);
    chk("midrst_sel", 32'(u_if.bus_sel_ac), 32'd0);
    chk("midrst_alu", 32'(u_if.alu_control), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      dn += int'(u_if.done);
    end
    chk("midrst_no_done", 32'(dn), 32'd0);
    chk("midrst_ac_kept", 32'(ac0), 32'd11);
    ops = '{16'd1, 16'd1, 16'd1, 16'd1};
    run_job("post_rst", 1'b1, 4, 0, 0, 6, 16'd1, 1'b0, 7'd2);
    dsel = 1;
    ops = '{16'd77, 16'd0, 16'd0, 16'd0};
    run_job("n1", 1'b1, 1, 0, 0, 3, 16'd77, 1'b0, 7'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ac_alu_seq.md
# ac_alu_seq

Sequencer for the accumulator/ALU datapath that computes one downsampled pixel per request: it loads the first operand into AC, accumulates the remaining 2^LOG2_N − 1 operands, then optionally divides by 2^LOG2_N with a right shift. It sits between the downsampling control FSM (start/done) and the AC/ALU datapath.
- It drives only datapath controls and the bus-source select.
- Operand data travels on the shared bus and never passes through this block.

## Interface
- LOG2_N, default 2: log2 of the operand count per job. Legal range 0..4 (1..16 operands).
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- avg_mode  input  1  1 = average (sum >> LOG2_N); 0 = sum only. Sampled with start.
- opnd_req  output  1  sequencer is ready to consume an operand from the bus.
- opnd_valid  input  1  operand present on the bus this cycle.
- bus_sel_ac  output  1  1 = bus driven from the AC output (used for the shift step); 0 = bus driven from the operand source.
- ac_control  output  2  bit0 = AC input select (0 bus, 1 ALU); bit1 = AC write enable.
- alu_control  output  3  ALU opcode: 000 ADD, 100 SHR.
- inst_const  output  7  constant operand to the ALU.
- z_flag  input  1  AC-is-zero flag from the datapath.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse; AC holds the result while done is high.
- result_zero  output  1  done & z_flag.

## Operation
- States: IDLE, LOAD, ACCUM, SHIFT, DONE. A 5-bit operand counter cnt and a registered mode bit are also kept.
- IDLE:
  - All control outputs are 0.
  - start=1 → latch avg_mode, set cnt=0, go to LOAD.
- LOAD:
  - opnd_req=1, bus_sel_ac=0.
  - ac_control = {opnd_valid, 0}: when valid, AC loads the bus value.
  - alu_control=000, inst_const=0.
  - On accept (opnd_req & opnd_valid): cnt←1.
    - If 2^LOG2_N == 1: go to SHIFT when mode=1, otherwise go to DONE.
    - Else go to ACCUM.
- ACCUM:
  - opnd_req=1.
  - ac_control = {opnd_valid, 1}, alu_control=000.
  - inst_const=0 is mandatory, because ADD computes AC + bus + const.
  - On accept: cnt←cnt+1.
  - When the accepted operand is the last one (cnt == 2^LOG2_N − 1 before the increment), go to SHIFT if mode=1, else to DONE.
- SHIFT:
  - bus_sel_ac=1, opnd_req=0.
  - ac_control=11, alu_control=100, inst_const=LOG2_N (zero-extended).
  - The ALU shifts its bus input, so AC must be routed onto the bus in this state.
  - Always lasts exactly one cycle, then goes to DONE.
- DONE: done=1, all datapath controls 0 (AC holds). Goes to IDLE the next cycle.
- Outputs:
  - ac_control and opnd_req are combinational in opnd_valid and state.
  - All other outputs decode from registered state only.
- Arithmetic:
  - Sums wrap modulo 2^16; no saturation or overflow flag.
  - The shift is logical (zero fill) and truncates toward zero.
- Control rules:
  - start while busy is ignored (no queueing).
  - opnd_valid outside LOAD/ACCUM is ignored and causes no AC write.
- Reset:
  - rst at any time → IDLE, cnt=0, mode=0, all outputs 0.
  - An in-flight job is discarded and no done is issued.
  - AC contents are not touched by this block.

## Timing
- start sampled at edge E0 → busy=1 and opnd_req=1 from E0 onward.
- With opnd_valid held high, operands are accepted at E1..EN, where N=2^LOG2_N.
- Average mode:
  - SHIFT occupies the cycle after EN and AC is written at E(N+1).
  - done=1 between E(N+1) and E(N+2).
  - Total: start to done = N+1 edges.
- Sum mode: done=1 between EN and E(N+1).
- Each cycle with opnd_valid=0 in LOAD/ACCUM adds exactly one cycle of stall, with no AC write.
- busy falls at the edge that leaves DONE. A new start can be sampled in the IDLE cycle that follows, giving a minimum job spacing of N+3 cycles in average mode.

## Test plan
- LOG2_N=2, avg_mode=1, operands 10,20,30,40 with valid always high → done 6 edges after start, AC=25, result_zero=0.
- Same operands with avg_mode=0 → done 5 edges after start, AC=100, no SHIFT cycle, bus_sel_ac never asserted.
- Operands 3,3,3,4 with opnd_valid low for 2 cycles between each operand → AC=13>>2=3. No AC write occurs during the gaps, and done is delayed by 6 cycles.
- Operands 0,0,0,0 in average mode → AC=0 and result_zero=1 during the done pulse. Also, start pulsed during ACCUM → ignored; exactly one done pulse.
- rst asserted mid-ACCUM after 2 operands → all outputs 0 immediately, no done. A new job with 1,1,1,1 then yields AC=1.
- LOG2_N=0, avg_mode=1, operand 77 → LOAD, SHIFT with inst_const=0, done; AC=77.
